// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: register map, status/control bit positions and drain FSM encoding
package uart_tx_fifo_pkg;
  localparam logic [1:0] UART_TXF_DATA = 2'b00;
  localparam logic [1:0] UART_TXF_STAT = 2'b01;
  localparam logic [1:0] UART_TXF_CTRL = 2'b10;
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVF = 2;
  localparam int STAT_BUSY = 3;
  localparam int STAT_COUNT = 8;
  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR_OVF = 1;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: circular buffer with push, pop and flush; flush overrides both push and pop
module sync_fifo #(
  parameter int W = 8,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  logic [W-1:0] mem_q [2**AW];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign full_o = count_q == DEPTH;
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !flush_i && !full_o;
  assign do_pop = pop_i && !flush_i && !empty_o;
  always_comb begin
    wptr_d = flush_i ? '0 : wptr_q + AW'(do_push);
    rptr_d = flush_i ? '0 : rptr_q + AW'(do_pop);
    count_d = flush_i ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wptr_q] <= wdata_i;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: bus-writable transmit FIFO draining one byte per tx_done into the UART transceiver
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] dat_i,
  input  logic [31:0] adr_i,
  input  logic        we_i,
  input  logic        stb_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_done,
  output logic        tx_empty_irq
);
  logic [7:0] head;
  logic [DEPTH_LOG2:0] count;
  logic full, empty, wr, push, flush, clr_ovf, pop, ovf_q, ovf_d;
  logic [31:0] stat;
  logic [7:0] tx_data_q;
  logic tx_wr_q;
  state_e state_q;
  logic unused;
  assign unused = ^{dat_i[31:8], adr_i[31:2]};
  assign wr = stb_i && we_i;
  assign push = wr && adr_i[1:0] == UART_TXF_DATA;
  assign flush = wr && adr_i[1:0] == UART_TXF_CTRL && dat_i[CTRL_FLUSH];
  assign clr_ovf = wr && adr_i[1:0] == UART_TXF_CTRL && dat_i[CTRL_CLR_OVF];
  assign pop = state_q == IDLE && !empty;
  sync_fifo #(.W(8), .AW(DEPTH_LOG2)) u_fifo (
    .clk_i(sys_clk),
    .rst_i(sys_rst),
    .push_i(push),
    .pop_i(pop),
    .flush_i(flush),
    .wdata_i(dat_i[7:0]),
    .rdata_o(head),
    .count_o(count),
    .full_o(full),
    .empty_o(empty)
  );
  // a flush in the same cycle discards the push silently, so it never counts as overflow
  assign ovf_d = clr_ovf ? 1'b0 : (push && full && !flush) ? 1'b1 : ovf_q;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q <= IDLE;
      tx_data_q <= '0;
      tx_wr_q <= 1'b0;
    end else begin
      tx_wr_q <= 1'b0;
      if (pop) begin
        tx_data_q <= head;
        tx_wr_q <= 1'b1;
        state_q <= BUSY;
      end else if (state_q == BUSY && tx_done) state_q <= IDLE;
    end
  always_comb begin
    stat = '0;
    stat[STAT_EMPTY] = empty;
    stat[STAT_FULL] = full;
    stat[STAT_OVF] = ovf_q;
    stat[STAT_BUSY] = state_q == BUSY;
    stat[STAT_COUNT +: DEPTH_LOG2+1] = count;
  end
  assign dat_o = adr_i[1:0] == UART_TXF_STAT ? stat : '0;
  assign ack_o = stb_i;
  assign tx_data = tx_data_q;
  assign tx_wr = tx_wr_q;
  assign tx_empty_irq = empty && state_q == IDLE;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table vectors, directed corner sequences and random traffic against a queue model
module tb_uart_tx_fifo;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [31:0] dat_i = '0, adr_i = '0, dat_o;
  logic we_i = 1'b0, stb_i = 1'b0, ack_o, tx_wr, tx_done = 1'b0, tx_empty_irq;
  logic [7:0] tx_data;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .dat_i(dat_i), .adr_i(adr_i),
    .we_i(we_i), .stb_i(stb_i), .dat_o(dat_o), .ack_o(ack_o),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done), .tx_empty_irq(tx_empty_irq)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0, n_err = 0;
  byte unsigned q[$];
  bit m_busy = 0, m_ovf = 0;
  logic [7:0] m_txd = '0;
  logic [31:0] rd_last;

  typedef struct {
    bit stb, we;
    logic [1:0] adr;
    logic [31:0] dat;
    bit done;
    logic [31:0] rd;
    bit wr;
    logic [7:0] txd;
    bit irq;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_stat();
    logic [31:0] s;
    s = 32'(q.size()) << 8;
    if (m_busy) s |= 32'h8;
    if (m_ovf) s |= 32'h4;
    if (q.size() == 16) s |= 32'h2;
    if (q.size() == 0) s |= 32'h1;
    return s;
  endfunction

  task automatic step(input bit stb, input bit we, input logic [1:0] adr, input logic [31:0] dat, input bit done);
    bit push, flush, clr, ld, was_full;
    stb_i = stb; we_i = we; adr_i = {30'($urandom()), adr}; dat_i = dat; tx_done = done;
    #1;
    rd_last = dat_o;
    chk("ack", 32'(ack_o), 32'(stb));
    chk("dat_o", dat_o, adr == 2'd1 ? m_stat() : 32'h0);
    @(posedge sys_clk);
    #1;
    push = stb && we && adr == 2'd0;
    flush = stb && we && adr == 2'd2 && dat[0];
    clr = stb && we && adr == 2'd2 && dat[1];
    was_full = q.size() == 16;
    ld = !m_busy && q.size() > 0;
    if (ld) m_txd = q[0];
    m_busy = m_busy ? !done : ld;
    if (flush) q.delete();
    else begin
      if (ld) void'(q.pop_front());
      if (push) begin
        if (was_full) m_ovf = 1;
        else q.push_back(dat[7:0]);
      end
    end
    if (clr) m_ovf = 0;
    chk("tx_wr", 32'(tx_wr), 32'(ld));
    chk("tx_data", 32'(tx_data), 32'(m_txd));
    chk("irq", 32'(tx_empty_irq), 32'(q.size() == 0 && !m_busy));
  endtask

  task automatic wr(input logic [1:0] adr, input logic [31:0] dat);
    step(1, 1, adr, dat, 0);
  endtask

  task automatic idle(input bit done);
    step(1, 0, 2'd1, 32'h0, done);
  endtask

  task automatic do_reset();
    stb_i = 1'b0; we_i = 1'b0; adr_i = 32'h1; tx_done = 1'b0;
    #3 sys_rst = 1'b1;
    #1;
    chk("rst_tx_wr", 32'(tx_wr), 32'h0);
    chk("rst_irq", 32'(tx_empty_irq), 32'h1);
    chk("rst_stat", dat_o, 32'h1);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    q.delete(); m_busy = 0; m_ovf = 0; m_txd = '0;
  endtask

  initial begin
    byte unsigned got[$];
    byte unsigned pp_exp[3];
    int rate;
    vecs = '{
      '{1'b1, 1'b0, 2'd1, 32'h0,    1'b0, 32'h1,   1'b0, 8'h00, 1'b1},
      '{1'b1, 1'b1, 2'd0, 32'h41,   1'b0, 32'h0,   1'b0, 8'h00, 1'b0},
      '{1'b1, 1'b0, 2'd1, 32'h0,    1'b0, 32'h100, 1'b1, 8'h41, 1'b0},
      '{1'b1, 1'b0, 2'd1, 32'h0,    1'b0, 32'h9,   1'b0, 8'h41, 1'b0},
      '{1'b1, 1'b0, 2'd1, 32'h0,    1'b1, 32'h9,   1'b0, 8'h41, 1'b1},
      '{1'b0, 1'b0, 2'd1, 32'h0,    1'b0, 32'h1,   1'b0, 8'h41, 1'b1},
      '{1'b1, 1'b0, 2'd1, 32'h0,    1'b1, 32'h1,   1'b0, 8'h41, 1'b1},
      '{1'b1, 1'b1, 2'd3, 32'hFF,   1'b0, 32'h0,   1'b0, 8'h41, 1'b1},
      '{1'b1, 1'b1, 2'd1, 32'hFFFF, 1'b0, 32'h1,   1'b0, 8'h41, 1'b1},
      '{1'b1, 1'b0, 2'd2, 32'h0,    1'b0, 32'h0,   1'b0, 8'h41, 1'b1},
      '{1'b1, 1'b0, 2'd1, 32'h0,    1'b0, 32'h1,   1'b0, 8'h41, 1'b1}
    };
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    chk("init_irq", 32'(tx_empty_irq), 32'h1);
    chk("init_tx_data", 32'(tx_data), 32'h0);

    foreach (vecs[i]) begin
      step(vecs[i].stb, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].done);
      chk($sformatf("vec%0d_rd", i), rd_last, vecs[i].rd);
      chk($sformatf("vec%0d_wr", i), 32'(tx_wr), 32'(vecs[i].wr));
      chk($sformatf("vec%0d_txd", i), 32'(tx_data), 32'(vecs[i].txd));
      chk($sformatf("vec%0d_irq", i), 32'(tx_empty_irq), 32'(vecs[i].irq));
    end

    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr(2'd0, 32'h10 + 32'(i));
      if (i == 1) begin
        chk("burst_first_wr", 32'(tx_wr), 32'h1);
        chk("burst_first_data", 32'(tx_data), 32'h10);
      end
    end
    idle(0);
    chk("burst_stat", rd_last, 32'h0F08);
    for (int i = 0; i < 15; i++) begin
      idle(1);
      idle(0);
      chk($sformatf("burst_wr%0d", i), 32'(tx_wr), 32'h1);
      chk($sformatf("burst_data%0d", i), 32'(tx_data), 32'h11 + 32'(i));
    end

    for (int i = 0; i < 17; i++) wr(2'd0, 32'h60 + 32'(i));
    idle(0);
    chk("ovf_stat", rd_last, 32'h100E);
    wr(2'd2, 32'h2);
    idle(0);
    chk("ovf_clr_stat", rd_last, 32'h100A);
    wr(2'd2, 32'h1);
    idle(0);
    chk("flush_full_stat", rd_last, 32'h0009);
    idle(1);
    chk("flush_full_irq", 32'(tx_empty_irq), 32'h1);

    for (int i = 0; i < 5; i++) wr(2'd0, 32'h30 + 32'(i));
    wr(2'd2, 32'h1);
    idle(0);
    chk("flush_busy_stat", rd_last, 32'h0009);
    repeat (4) idle(0);
    chk("flush_busy_irq_hold", 32'(tx_empty_irq), 32'h0);
    idle(1);
    chk("flush_done_irq", 32'(tx_empty_irq), 32'h1);

    for (int i = 0; i < 4; i++) wr(2'd0, 32'h70 + 32'(i));
    idle(1);
    wr(2'd0, 32'h5A);
    chk("pp_pop_wr", 32'(tx_wr), 32'h1);
    idle(0);
    chk("pp_stat", rd_last, 32'h0308);
    pp_exp = '{8'h72, 8'h73, 8'h5A};
    repeat (3) begin
      idle(1);
      idle(0);
      if (tx_wr) got.push_back(tx_data);
    end
    chk("pp_count", 32'(got.size()), 32'h3);
    foreach (got[i]) if (i < 3) chk($sformatf("pp_byte%0d", i), 32'(got[i]), 32'(pp_exp[i]));

    wr(2'd0, 32'hAA);
    wr(2'd0, 32'hBB);
    wr(2'd0, 32'hCC);
    do_reset();
    idle(0);
    chk("post_rst_stat", rd_last, 32'h1);
    idle(1);
    chk("stray_done_wr", 32'(tx_wr), 32'h0);
    idle(0);
    chk("stray_done_wr2", 32'(tx_wr), 32'h0);

    rate = 4;
    for (int c = 0; c < 4000; c++) begin
      int r;
      logic [1:0] a;
      logic [31:0] d;
      if (c % 400 == 0) rate = $urandom_range(1, 14);
      r = $urandom_range(0, 99);
      a = r < 55 ? 2'd0 : r < 80 ? 2'd1 : r < 86 ? 2'd2 : 2'd3;
      d = $urandom();
      if (a == 2'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      step($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 60, a, d, $urandom_range(1, rate) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side buffer that sits directly upstream of the UART transceiver. It accepts bytes from the CPU bus into a FIFO and drains them one at a time into the transceiver's `tx_data`/`tx_wr` input, waiting for `tx_done` between bytes. The CPU can queue a burst of bytes without polling per character, and gets a level interrupt when the line has fully drained.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `sys_clk`  in  1  system clock; all state updates on its rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `dat_i`  in  32  bus write data.
- `adr_i`  in  32  bus address; only `[1:0]` is decoded.
- `we_i`  in  1  bus write enable.
- `stb_i`  in  1  bus strobe.
- `dat_o`  out  32  bus read data, combinational from current state.
- `ack_o`  out  1  equals `stb_i` (zero-wait-state slave).
- `tx_data`  out  8  byte to transceiver, registered, held stable until next load.
- `tx_wr`  out  1  one-cycle load pulse to transceiver, registered.
- `tx_done`  in  1  one-cycle pulse from transceiver when the stop bit is sent.
- `tx_empty_irq`  out  1  level: FIFO empty and no byte in flight.

## Operation
- A bus access occurs in any cycle with `stb_i` high. Writes take effect on that cycle's `sys_clk` edge.
- Address map (`adr_i[1:0]`):
  - 00 write: push `dat_i[7:0]`. Read: returns 0.
  - 01 read: status. Bit 0 = empty, bit 1 = full, bit 2 = overflow (sticky), bit 3 = busy, bits `[8+DEPTH_LOG2:8]` = count. All other bits are 0. Writes are ignored.
  - 10 write: bit 0 = flush, bit 1 = clear overflow. Read: returns 0.
  - 11: reserved. Reads return 0; writes are ignored.
- Storage:
  - Circular buffer with read and write pointers of width DEPTH_LOG2; pointers wrap modulo depth.
  - `count` is DEPTH_LOG2+1 bits wide, range 0..2^DEPTH_LOG2.
  - `full` means `count == 2^DEPTH_LOG2`; `empty` means `count == 0`.
- Drain FSM:
  - IDLE: if not empty, load `tx_data` with the head entry, pulse `tx_wr`, pop, and go to BUSY.
  - BUSY: on `tx_done`, go to IDLE.
  - `busy` = state is BUSY.
  - `tx_done` received in IDLE is ignored.
- Boundary rules:
  - Push when full: data is dropped, `overflow` is set, count is unchanged.
  - Push and pop in the same cycle: both happen; count is unchanged. When full, a simultaneous pop does not make room, so the push is dropped and `overflow` is set.
  - Flush: pointers and count go to 0. The FSM state is not touched; a byte already handed to the transceiver completes, and BUSY waits for its `tx_done`.
  - Flush and push in the same cycle: flush wins and the push is dropped; `overflow` is not set.
  - Flush and clear-overflow may be combined in one write.
  - `tx_empty_irq` = empty AND NOT busy.
- Reset values:
  - Pointers, count, overflow: 0. FSM: IDLE.
  - `tx_data` = 0, `tx_wr` = 0, so `tx_empty_irq` = 1.
  - `dat_o` and `ack_o` follow their combinational definitions.
- Reset mid-operation: all state clears immediately and queued bytes are lost. Any `tx_done` that arrives afterwards while IDLE is ignored.

## Timing
- Push on edge k into an empty FIFO, FSM idle:
  - `count` = 1 after edge k.
  - FSM loads at edge k+1, so `tx_wr` is high for exactly one cycle between edges k+1 and k+2.
  - `count` returns to 0 after edge k+1.
- `tx_done` sampled at edge j with FIFO non-empty: FSM is IDLE after edge j, and the next `tx_wr` pulse follows edge j+1.
- `tx_wr` is never high in two consecutive cycles.
- Status reads reflect state after the previous edge; a read in the same cycle as a push does not include that push.

## Structure
- Shared package holds:
  - address constants `UART_TXF_DATA` = 2'b00, `UART_TXF_STAT` = 2'b01, `UART_TXF_CTRL` = 2'b10;
  - status bit indices;
  - FSM state encoding (IDLE = 1'b0, BUSY = 1'b1).
- One natural sub-module: `sync_fifo`, a parameterised width/depth circular buffer with push, pop, flush, count, full and empty. The drain FSM and bus decode stay in the top module.

## Test plan
- Reset: assert `sys_rst` mid-transfer, then release → status reads 0x0000_0001 (empty only), `tx_empty_irq` = 1, `tx_wr` = 0, and a stray `tx_done` causes no `tx_wr`.
- Single byte: write 0x41 to addr 0 at edge k → `tx_wr` pulses once after edge k+1 with `tx_data` = 0x41; status busy = 1; after a `tx_done` pulse, status = 0x0000_0001 and `tx_empty_irq` = 1.
- Burst order: write 0x10..0x1F back-to-back while `tx_done` is withheld → first `tx_wr` carries 0x10, count settles at 15, full = 0. Then 15 `tx_done` pulses → bytes 0x11..0x1F appear in order, one `tx_wr` per `tx_done`.
- Overflow: with the drain stalled, write 17 bytes → full = 1, overflow = 1, count = 16 (status 0x0000_1006 with busy = 0, or 0x0000_100E if one byte is in flight). Write 0x2 to addr 2 → overflow = 0.
- Flush while busy: queue 5 bytes, flush on addr 2 → count = 0 and busy stays 1 until `tx_done`; no further `tx_wr`; then `tx_empty_irq` = 1.
- Simultaneous push/pop: with count = 3 in IDLE, push on the same edge as the FSM pop → count = 3, and the pushed byte drains last.
